// File: rtl/bomb_fuse_timer.sv
// Bomb fuse timer: IDLE -> FUSE (FUSE_TICKS) -> BLAST (BLAST_TICKS) -> DONE; CHAIN_DETONATE_EN enables early chain detonation.
// Latency: arm seen at edge N gives fuse_on from N+1; all outputs come from registered state.
// No backpressure: arm in any non-IDLE state is dropped, never queued.
module bomb_fuse_timer #(
    parameter int FUSE_TICKS  = 12,
    parameter int BLAST_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       arm,
    input  logic       chain,
    output logic       busy,
    output logic       fuse_on,
    output logic       explode,
    output logic       blast_active,
    output logic       done,
    output logic [7:0] ticks_left
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FUSE  = 2'd1,
        S_BLAST = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] FUSE_INIT  = 8'(FUSE_TICKS);
    localparam logic [7:0] BLAST_INIT = 8'(BLAST_TICKS);

    state_t     state_q, state_d;
    logic [7:0] ticks_q, ticks_d;
    logic       explode_q, explode_d;
    logic       chain_req;

`ifdef CHAIN_DETONATE_EN
    assign chain_req = chain;
`else
    // Port kept for pin compatibility; the fuse always runs its full length.
    logic unused_chain;
    assign unused_chain = chain;
    assign chain_req    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ticks_q   <= 8'd0;
            explode_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ticks_q   <= ticks_d;
            explode_q <= explode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ticks_d = ticks_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_FUSE;
                    ticks_d = FUSE_INIT;
                end
            end
            S_FUSE: begin
                // Chain wins over a coincident tick, so the blast is entered only once.
                if (chain_req || (tick && ticks_q <= 8'd1)) begin
                    state_d = S_BLAST;
                    ticks_d = BLAST_INIT;
                end else if (tick) begin
                    ticks_d = ticks_q - 8'd1;
                end
            end
            S_BLAST: begin
                if (tick) begin
                    if (ticks_q <= 8'd1) begin
                        state_d = S_DONE;
                        ticks_d = 8'd0;
                    end else begin
                        ticks_d = ticks_q - 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ticks_d = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                ticks_d = 8'd0;
            end
        endcase
        explode_d = (state_d == S_BLAST) && (state_q != S_BLAST);
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        fuse_on      = (state_q == S_FUSE);
        blast_active = (state_q == S_BLAST);
        done         = (state_q == S_DONE);
        explode      = explode_q;
        ticks_left   = ticks_q;
    end

endmodule

// File: tb/tb_bomb_fuse_timer.sv
// Self-checking bench for bomb_fuse_timer: directed scenarios plus random stimulus against a phase/countdown model.
module tb_bomb_fuse_timer;

    localparam int FT = 12;
    localparam int BT = 4;

`ifdef CHAIN_DETONATE_EN
    localparam bit CHAIN_EN = 1'b1;
`else
    localparam bit CHAIN_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, tick, arm, chain;
    logic       busy, fuse_on, explode, blast_active, done;
    logic [7:0] ticks_left;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: which phase the bomb is in and how many ticks remain in it.
    string m_phase = "idle";
    int    m_left  = 0;
    bit    m_boom  = 1'b0;
    int    n_expl  = 0;
    int    n_done  = 0;

    bomb_fuse_timer #(.FUSE_TICKS(FT), .BLAST_TICKS(BT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .arm(arm), .chain(chain),
        .busy(busy), .fuse_on(fuse_on), .explode(explode),
        .blast_active(blast_active), .done(done), .ticks_left(ticks_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit a, input bit t, input bit c);
        m_boom = 1'b0;
        if (r) begin
            m_phase = "idle";
            m_left  = 0;
        end else if (m_phase == "idle") begin
            if (a) begin
                m_phase = "fuse";
                m_left  = FT;
            end
        end else if (m_phase == "fuse") begin
            if (CHAIN_EN && c) begin
                m_phase = "blast"; m_left = BT; m_boom = 1'b1;
            end else if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_phase = "blast"; m_left = BT; m_boom = 1'b1;
                end
            end
        end else if (m_phase == "blast") begin
            if (t) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = "done";
            end
        end else begin
            m_phase = "idle";
            m_left  = 0;
        end
    endtask

    task automatic step(input bit r, input bit a, input bit t, input bit c);
        reset = r; arm = a; tick = t; chain = c;
        @(posedge clk);
        model(r, a, t, c);
        #1;
        check("busy",         int'(busy),         int'(m_phase != "idle"));
        check("fuse_on",      int'(fuse_on),      int'(m_phase == "fuse"));
        check("blast_active", int'(blast_active), int'(m_phase == "blast"));
        check("done",         int'(done),         int'(m_phase == "done"));
        check("explode",      int'(explode),      int'(m_boom));
        check("ticks_left",   int'(ticks_left),   m_left);
        if (explode === 1'b1) n_expl++;
        if (done === 1'b1) n_done++;
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n, input int gap, input bit a, input bit c);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) step(1'b0, a, 1'b0, c);
            step(1'b0, a, 1'b1, c);
        end
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; tick = 1'b0; chain = 1'b0;
        @(negedge clk);

        // Reset state, including a tick/arm/chain held during reset.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_ticks", int'(ticks_left), 0);

        // Full default sequence, ticks spaced 5 cycles; arm coincident with tick is not counted.
        n_expl = 0; n_done = 0;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("arm_load", int'(ticks_left), 12);
        run_ticks(FT + BT, 5, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("full_expl_cnt", n_expl, 1);
        check("full_done_cnt", n_done, 1);

`ifdef CHAIN_DETONATE_EN
        // Chain after 3 ticks detonates immediately.
        n_expl = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(3, 2, 1'b0, 1'b0);
        check("pre_chain", int'(ticks_left), 9);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("chain_expl", int'(explode), 1);
        check("chain_blast_load", int'(ticks_left), 4);
        run_ticks(BT, 2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // Tick and chain together at ticks_left=5 gives a single explode.
        n_expl = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(7, 2, 1'b0, 1'b0);
        check("pre_both", int'(ticks_left), 5);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("both_load", int'(ticks_left), 4);
        run_ticks(BT, 2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("both_expl_cnt", n_expl, 1);
`else
        // Chain held through FUSE is ignored; explode only after the 12th tick.
        n_expl = 0;
        step(1'b0, 1'b1, 1'b0, 1'b1);
        run_ticks(FT - 1, 3, 1'b0, 1'b1);
        check("chain_ign_left", int'(ticks_left), 1);
        check("chain_ign_noexpl", n_expl, 0);
        run_ticks(1 + BT, 3, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("chain_ign_expl_cnt", n_expl, 1);
`endif

        // arm re-pulsed in FUSE and held through BLAST: no effect, one done.
        n_done = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(5, 2, 1'b0, 1'b0);
        check("rearm_pre", int'(ticks_left), 7);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("rearm_fuse", int'(ticks_left), 7);
        run_ticks(7 + BT, 2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rearm_idle", int'(busy), 0);
        check("rearm_done_cnt", n_done, 1);

        // Reset mid-BLAST at ticks_left=2 aborts silently; new arm restarts cleanly.
        n_done = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_ticks(FT + 2, 2, 1'b0, 1'b0);
        check("pre_rst_left", int'(ticks_left), 2);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_no_done", n_done, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_rearm", int'(ticks_left), 12);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
